// File: rtl/spu_ex_issue_sched.sv
// In-order issue/writeback scheduler for the 128-bit SPU execute stage. Results wait in a
// latency-indexed shift pipeline and leave through the single register-file write port.
module spu_ex_issue_sched #(
   parameter int unsigned LAT_W   = 3,
   parameter int unsigned MAX_LAT = 7,
   parameter int unsigned REG_W   = 7,
   parameter int unsigned DATA_W  = 128
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              issue_valid,
   output logic              issue_ready,
   input  logic [LAT_W-1:0]  issue_latency,
   input  logic [REG_W-1:0]  issue_rt,
   input  logic [DATA_W-1:0] issue_data,
   input  logic [REG_W-1:0]  issue_ra,
   input  logic [REG_W-1:0]  issue_rb,
   input  logic [REG_W-1:0]  issue_rc,
   input  logic              issue_ra_v,
   input  logic              issue_rb_v,
   input  logic              issue_rc_v,
   output logic              wb_valid,
   output logic [REG_W-1:0]  wb_rt,
   output logic [DATA_W-1:0] wb_data,
   output logic              busy,
   output logic [LAT_W:0]    inflight_cnt,
   output logic [31:0]       stall_cycles
);

   logic [MAX_LAT-1:0] v_q, v_d;
   logic [REG_W-1:0]   rt_q   [MAX_LAT];
   logic [REG_W-1:0]   rt_d   [MAX_LAT];
   logic [DATA_W-1:0]  data_q [MAX_LAT];
   logic [DATA_W-1:0]  data_d [MAX_LAT];
   logic [31:0]        stall_q, stall_d;
   logic [LAT_W-1:0]   leff;
   logic               slot_conflict, raw, waw;
   logic [LAT_W:0]     cnt;

   assign leff = (issue_latency == '0) ? LAT_W'(1) : issue_latency;

   // Stage k writes back k cycles from now, so a valid st[leff] owns the slot we want.
   always_comb begin
      slot_conflict = 1'b0;
      raw           = 1'b0;
      waw           = 1'b0;
      for (int k = 0; k < MAX_LAT; k++) begin
         if (v_q[k]) begin
            if (LAT_W'(k) == leff) slot_conflict = 1'b1;
            if ((issue_ra_v && issue_ra == rt_q[k]) ||
                (issue_rb_v && issue_rb == rt_q[k]) ||
                (issue_rc_v && issue_rc == rt_q[k])) raw = 1'b1;
            if (issue_rt == rt_q[k]) waw = 1'b1;
         end
      end
   end

   assign issue_ready = !flush && !slot_conflict && !raw && !waw;

   always_comb begin
      for (int k = 0; k < MAX_LAT - 1; k++) begin
         v_d[k]    = v_q[k+1];
         rt_d[k]   = rt_q[k+1];
         data_d[k] = data_q[k+1];
      end
      v_d[MAX_LAT-1]    = 1'b0;
      rt_d[MAX_LAT-1]   = '0;
      data_d[MAX_LAT-1] = '0;
      if (issue_valid && issue_ready) begin
         for (int k = 0; k < MAX_LAT; k++) begin
            if (LAT_W'(k + 1) == leff) begin
               v_d[k]    = 1'b1;
               rt_d[k]   = issue_rt;
               data_d[k] = issue_data;
            end
         end
      end
      stall_d = stall_q;
      if (issue_valid && !issue_ready && stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v_q     <= '0;
         stall_q <= '0;
         for (int k = 0; k < MAX_LAT; k++) begin
            rt_q[k]   <= '0;
            data_q[k] <= '0;
         end
      end else begin
         stall_q <= stall_d;
         if (flush) begin
            v_q <= '0;
         end else begin
            v_q    <= v_d;
            rt_q   <= rt_d;
            data_q <= data_d;
         end
      end
   end

   always_comb begin
      cnt = '0;
      for (int k = 0; k < MAX_LAT; k++) cnt = cnt + (LAT_W + 1)'(v_q[k]);
   end

   assign wb_valid     = v_q[0];
   assign wb_rt        = rt_q[0];
   assign wb_data      = data_q[0];
   assign busy         = |v_q;
   assign inflight_cnt = cnt;
   assign stall_cycles = stall_q;

endmodule

// File: tb/tb_spu_ex_issue_sched.sv
// Randomized bench for spu_ex_issue_sched against a due-time based reference model.
module tb_spu_ex_issue_sched;

   localparam int unsigned LAT_W   = 3;
   localparam int unsigned MAX_LAT = 7;
   localparam int unsigned REG_W   = 7;
   localparam int unsigned DATA_W  = 128;

   logic              clk = 1'b0;
   logic              reset, flush, issue_valid, issue_ready;
   logic [LAT_W-1:0]  issue_latency;
   logic [REG_W-1:0]  issue_rt, issue_ra, issue_rb, issue_rc;
   logic [DATA_W-1:0] issue_data;
   logic              issue_ra_v, issue_rb_v, issue_rc_v;
   logic              wb_valid, busy;
   logic [REG_W-1:0]  wb_rt;
   logic [DATA_W-1:0] wb_data;
   logic [LAT_W:0]    inflight_cnt;
   logic [31:0]       stall_cycles;

   spu_ex_issue_sched #(
      .LAT_W(LAT_W), .MAX_LAT(MAX_LAT), .REG_W(REG_W), .DATA_W(DATA_W)
   ) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_latency(issue_latency), .issue_rt(issue_rt), .issue_data(issue_data),
      .issue_ra(issue_ra), .issue_rb(issue_rb), .issue_rc(issue_rc),
      .issue_ra_v(issue_ra_v), .issue_rb_v(issue_rb_v), .issue_rc_v(issue_rc_v),
      .wb_valid(wb_valid), .wb_rt(wb_rt), .wb_data(wb_data),
      .busy(busy), .inflight_cnt(inflight_cnt), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [REG_W-1:0]  rt;
      logic [DATA_W-1:0] data;
      int                due;
   } rec_t;

   rec_t        pend[$];
   int          now = 0;
   logic [31:0] m_stall = '0;
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string tag, input logic [DATA_W-1:0] got,
                        input logic [DATA_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, now);
      end
   endtask

   function automatic int eff_lat();
      return (issue_latency == 0) ? 1 : int'(issue_latency);
   endfunction

   // An instruction may go only if its writeback cycle is free and no pending result
   // is read or re-written by it.
   function automatic bit model_ready();
      if (flush) return 1'b0;
      foreach (pend[i]) begin
         if (pend[i].due == now + eff_lat()) return 1'b0;
         if (pend[i].rt == issue_rt) return 1'b0;
         if (issue_ra_v && pend[i].rt == issue_ra) return 1'b0;
         if (issue_rb_v && pend[i].rt == issue_rb) return 1'b0;
         if (issue_rc_v && pend[i].rt == issue_rc) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic step();
      bit                rdy, wbv;
      logic [REG_W-1:0]  wrt;
      logic [DATA_W-1:0] wd;
      rec_t              r;
      #1;
      rdy = model_ready();
      wbv = 1'b0;
      wrt = '0;
      wd  = '0;
      foreach (pend[i]) if (pend[i].due == now) begin
         wbv = 1'b1;
         wrt = pend[i].rt;
         wd  = pend[i].data;
      end
      check("issue_ready", DATA_W'(issue_ready), DATA_W'(rdy));
      check("wb_valid", DATA_W'(wb_valid), DATA_W'(wbv));
      if (wbv) begin
         check("wb_rt", DATA_W'(wb_rt), DATA_W'(wrt));
         check("wb_data", wb_data, wd);
      end
      check("busy", DATA_W'(busy), DATA_W'(pend.size() != 0));
      check("inflight_cnt", DATA_W'(inflight_cnt), DATA_W'(pend.size()));
      check("stall_cycles", DATA_W'(stall_cycles), DATA_W'(m_stall));
      @(posedge clk);
      if (reset) begin
         pend.delete();
         m_stall = '0;
      end else begin
         if (issue_valid && !rdy && m_stall != 32'hFFFF_FFFF) m_stall++;
         if (flush) begin
            pend.delete();
         end else begin
            for (int i = pend.size() - 1; i >= 0; i--) if (pend[i].due == now) pend.delete(i);
            if (issue_valid && rdy) begin
               r.rt   = issue_rt;
               r.data = issue_data;
               r.due  = now + eff_lat();
               pend.push_back(r);
            end
         end
      end
      now++;
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      reset = 0; flush = 0; issue_valid = 0; issue_latency = 0;
      issue_rt = 0; issue_data = '0; issue_ra = 0; issue_rb = 0; issue_rc = 0;
      issue_ra_v = 0; issue_rb_v = 0; issue_rc_v = 0;
   endtask

   initial begin
      idle_inputs();
      reset = 1;
      @(posedge clk);
      @(negedge clk);
      check("rst_wb_rt", DATA_W'(wb_rt), '0);
      check("rst_wb_data", wb_data, '0);
      step();
      reset = 0;

      // Single L=3 issue and its drain.
      issue_valid = 1; issue_latency = 3; issue_rt = 5; issue_data = {16{8'hA5}};
      step();
      idle_inputs();
      repeat (5) step();

      // Slot conflict: L=2 behind L=3 is held for a cycle.
      issue_valid = 1; issue_latency = 3; issue_rt = 1; step();
      issue_latency = 2; issue_rt = 2; issue_data = 128'h1234;
      repeat (2) step();
      idle_inputs();
      repeat (4) step();

      // RAW stall, with stall counter forced near saturation.
      issue_valid = 1; issue_latency = 4; issue_rt = 9; step();
      issue_rt = 10; issue_ra = 9; issue_ra_v = 1; issue_latency = 1;
      force dut.stall_q = 32'hFFFF_FFFE;
      #1;
      release dut.stall_q;
      m_stall = 32'hFFFF_FFFE;
      repeat (4) step();
      check("stall_saturated", DATA_W'(stall_cycles), DATA_W'(32'hFFFF_FFFF));
      step();
      idle_inputs();
      repeat (3) step();

      // Max latency back-to-back, then flush with entries in flight.
      for (int i = 0; i < 10; i++) begin
         issue_valid = 1; issue_latency = 7; issue_rt = REG_W'(20 + i);
         issue_data = {4{$urandom}};
         step();
      end
      issue_valid = 0; flush = 1; step();
      flush = 0; repeat (2) step();

      // Reset mid-stream.
      for (int i = 0; i < 3; i++) begin
         issue_valid = 1; issue_latency = 5; issue_rt = REG_W'(40 + i); step();
      end
      issue_valid = 1; issue_rt = 40; step();
      idle_inputs(); reset = 1; step();
      reset = 0; step();

      for (int n = 0; n < 3000; n++) begin
         reset         = ($urandom_range(0, 199) == 0);
         flush         = ($urandom_range(0, 29) == 0);
         issue_valid   = ($urandom_range(0, 9) < 8);
         issue_latency = LAT_W'($urandom_range(0, 7));
         issue_rt      = REG_W'($urandom_range(0, 15));
         issue_ra      = REG_W'($urandom_range(0, 15));
         issue_rb      = REG_W'($urandom_range(0, 15));
         issue_rc      = REG_W'($urandom_range(0, 15));
         issue_ra_v    = ($urandom_range(0, 3) == 0);
         issue_rb_v    = ($urandom_range(0, 3) == 0);
         issue_rc_v    = ($urandom_range(0, 3) == 0);
         issue_data    = {$urandom, $urandom, $urandom, $urandom};
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spu_ex_issue_sched.md
Name: spu_ex_issue_sched

Overview:
- In-order issue and writeback scheduler for the 128-bit SPU execute stage.
- Accepts one instruction per cycle together with its 128-bit result and the latency the execute unit reports.
- Holds each result in a latency-indexed reservation pipeline and drives the single register-file writeback port at exactly issue+latency.
- Stalls issue on a writeback-slot conflict, a RAW hazard or a WAW hazard against in-flight destinations.

Parameters:
- LAT_W, 3, width of the latency field.
- MAX_LAT, 7, deepest pipeline latency (2**LAT_W-1); this is also the reservation depth.
- REG_W, 7, register index width (128 registers).
- DATA_W, 128, result width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous squash of all in-flight entries.
- issue_valid  in  1  instruction presented.
- issue_ready  out  1  combinational; the instruction is accepted when issue_valid && issue_ready.
- issue_latency  in  LAT_W  execute latency; a value of 0 is treated as 1.
- issue_rt  in  REG_W  destination register.
- issue_data  in  DATA_W  result from the execute datapath.
- issue_ra, issue_rb, issue_rc  in  REG_W each  source registers.
- issue_ra_v, issue_rb_v, issue_rc_v  in  1 each  source is actually read.
- wb_valid  out  1  register-file write enable.
- wb_rt  out  REG_W  write address.
- wb_data  out  DATA_W  write data.
- busy  out  1  at least one entry is in flight (includes st[0]).
- inflight_cnt  out  LAT_W+1  number of valid entries in st[0..MAX_LAT-1].
- stall_cycles  out  32  saturating count of cycles with issue_valid && !issue_ready.

Behaviour:
- State is a stage array st[0..MAX_LAT-1]; each stage holds {v, rt, data}.
- Writeback outputs are driven directly by stage 0: wb_valid = st[0].v, wb_rt = st[0].rt, wb_data = st[0].data.
- Reset: all st[k].v=0, rt=0, data=0, stall_cycles=0. Consequently wb_valid=0, wb_rt=0, wb_data=0, busy=0, inflight_cnt=0 in the first cycle after reset.
- Reset during operation drops every in-flight entry; no writeback occurs afterwards for those entries.
- Per edge, when neither reset nor flush is asserted:
  - Shift: st[k] <= st[k+1] for k<MAX_LAT-1, and st[MAX_LAT-1] <= invalid.
  - Insert: on an accepted issue, with L = max(issue_latency, 1), st[L-1] <= {1, issue_rt, issue_data}.
- Latency: an instruction accepted in cycle T produces wb_valid in cycle T+L with its rt and data. Exactly one writeback occurs per accepted instruction.
- Define Leff = max(issue_latency, 1). issue_ready = !flush && !slot_conflict && !raw && !waw, where:
  - slot_conflict = (Leff < MAX_LAT) && st[Leff].v. At Leff = MAX_LAT there is never a slot conflict.
  - raw = any enabled source equals st[k].rt with st[k].v, for any k including 0. There is no bypass; the register file is written at the end of the wb cycle.
  - waw = issue_rt equals st[k].rt with st[k].v, for any k.
- issue_ready does not depend on issue_valid.
- Flush: on the edge where flush=1, all st[k].v <= 0 and no insert occurs. wb_valid may still be 1 during the flush cycle itself (st[0] commits); it is 0 the following cycle.
- Reset has priority over flush.
- Full throughput: back-to-back issues with non-decreasing latency and independent registers never stall.
- inflight_cnt is the popcount of st[*].v. busy = |st[*].v.
- stall_cycles:
  - increments on every cycle with issue_valid && !issue_ready, including flush cycles;
  - saturates at 0xFFFFFFFF;
  - is cleared only by reset.

Test Plan:
1. Reset, then issue L=3, rt=5, data=0xA5..A5 at cycle T -> wb_valid=1 only in T+3, wb_rt=5, wb_data=0xA5..A5; inflight_cnt goes 1,1,1, then 0 at T+4.
2. Structural conflict: issue L=3 (rt=1) at T, then L=2 (rt=2) at T+1 -> issue_ready=0 at T+1. If L=2 is held, it is accepted at T+2, and writebacks occur at T+3 (rt1) and T+4 (rt2). stall_cycles=1.
3. RAW: issue L=4, rt=9 at T; next issue has issue_ra=9, issue_ra_v=1 -> stalled T+1..T+4 and accepted at T+5. The same case with issue_ra_v=0 -> accepted at T+1.
4. Latency 0 and max: issue_latency=0 -> writeback at T+1. L=7 every cycle with distinct rt -> issue_ready constantly 1, and one writeback per cycle from T+7.
5. Flush: three entries in flight, flush pulsed at T -> no wb_valid from T+1 on, busy=0 and inflight_cnt=0 at T+1, issue_ready=0 during T.
6. Reset mid-stream with entries in flight -> all outputs 0 the next cycle and stall_cycles=0. Separately, force stall_cycles to 0xFFFFFFFE and hold a stall 3 cycles -> it reads 0xFFFFFFFF.
